// File: rtl/fpu_ctrl_pkg.sv
// Shared types and constants for the FPU command sequencer: op codes, FSM states,
// response flag bit positions and half-precision constants.
package fpu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } seq_state_e;

    localparam int FLG_MUL_OF = 0;
    localparam int FLG_MUL_UF = 1;
    localparam int FLG_DIV_UF = 2;
    localparam int FLG_DIV_OF = 3;
    localparam int FLG_TMO    = 4;

    localparam logic [15:0] F16_QNAN = 16'h7E00;
    localparam logic [15:0] F16_SIGN = 16'h8000;

    // ADD and SUB share the adder; SUB is realised by flipping the sign of B.
    function automatic logic uses_adder(input fpu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fpu_wdog.sv
// Watchdog for the WAIT phase: cleared before each wait, counts enabled cycles and
// flags the cycle that is the TIMEOUT_CYCLES-th enabled cycle since the clear.
module fpu_wdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);

    // Counter holds at LAST so it can never wrap if enable stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = i_enable && w_at_last;

endmodule

// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer in front of the add/sub, mult and div units: accepts one op,
// pulses the chosen unit's start, waits (watchdog-bounded) and returns result/flags/tag.
module fpu_op_sequencer
    import fpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_result,
    output logic [4:0]       resp_flags,
    output logic [TAG_W-1:0] resp_tag,
    output logic [15:0]      fpu_a,
    output logic [15:0]      fpu_b,
    output logic             add_start,
    input  logic             add_valid,
    input  logic [15:0]      add_sum,
    output logic             mul_start,
    input  logic             mul_valid,
    input  logic [15:0]      mul_product,
    input  logic             mul_uf,
    input  logic             mul_of,
    output logic             div_start,
    input  logic             div_valid,
    input  logic [15:0]      div_quotient,
    input  logic             div_uf,
    input  logic             div_of,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Both ports use plain valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; resp_valid and the resp_* payload stay constant
    // until that edge, and req_ready never depends combinationally on req_valid.

    seq_state_e       r_state;
    seq_state_e       w_next;
    fpu_op_e          r_op;
    logic [TAG_W-1:0] r_tag;
    logic [15:0]      r_a;
    logic [15:0]      r_b;
    logic [15:0]      r_result;
    logic [4:0]       r_flags;
    logic             r_req_ready;

    logic             w_accept;
    logic             w_in_wait;
    logic             w_expired;
    logic             w_unit_valid;
    logic [15:0]      w_unit_result;
    logic [4:0]       w_unit_flags;

    assign w_accept  = req_valid && r_req_ready;
    assign w_in_wait = (r_state == S_WAIT);

    fpu_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (reset),
        .i_clear  (r_state == S_ISSUE),
        .i_enable (w_in_wait),
        .o_expired(w_expired)
    );

    // Only the unit that was started is listened to; everything else is ignored.
    always_comb begin
        w_unit_valid  = 1'b0;
        w_unit_result = add_sum;
        w_unit_flags  = '0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_unit_valid  = add_valid;
                w_unit_result = add_sum;
            end
            OP_MUL: begin
                w_unit_valid             = mul_valid;
                w_unit_result            = mul_product;
                w_unit_flags[FLG_MUL_OF] = mul_of;
                w_unit_flags[FLG_MUL_UF] = mul_uf;
            end
            OP_DIV: begin
                w_unit_valid             = div_valid;
                w_unit_result            = div_quotient;
                w_unit_flags[FLG_DIV_UF] = div_uf;
                w_unit_flags[FLG_DIV_OF] = div_of;
            end
            default: begin
                w_unit_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_unit_valid || w_expired) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // req_ready is registered so it stays low through reset and rises one edge later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b0;
            r_op        <= OP_ADD;
            r_tag       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == S_IDLE);
            if (w_accept) begin
                r_op  <= fpu_op_e'(req_op);
                r_tag <= req_tag;
                r_a   <= req_a;
                r_b   <= (fpu_op_e'(req_op) == OP_SUB) ? (req_b ^ F16_SIGN) : req_b;
            end
            // A unit valid in the expiry cycle takes priority over the timeout.
            if (w_in_wait) begin
                if (w_unit_valid) begin
                    r_result <= w_unit_result;
                    r_flags  <= w_unit_flags;
                end else if (w_expired) begin
                    r_result         <= F16_QNAN;
                    r_flags          <= '0;
                    r_flags[FLG_TMO] <= 1'b1;
                end
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign busy        = (r_state != S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_result = r_result;
    assign resp_flags  = r_flags;
    assign resp_tag    = r_tag;
    assign fpu_a       = r_a;
    assign fpu_b       = r_b;
    assign add_start   = (r_state == S_ISSUE) && uses_adder(r_op);
    assign mul_start   = (r_state == S_ISSUE) && (r_op == OP_MUL);
    assign div_start   = (r_state == S_ISSUE) && (r_op == OP_DIV);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: unit models driven from tasks, expected responses from
// a reference model pushed into a queue and compared at each response handshake.
module tb_fpu_op_sequencer;

    localparam int TMO = 64;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [15:0]   req_a;
    logic [15:0]   req_b;
    logic [TW-1:0] req_tag;
    logic          resp_valid;
    logic          resp_ready;
    logic [15:0]   resp_result;
    logic [4:0]    resp_flags;
    logic [TW-1:0] resp_tag;
    logic [15:0]   fpu_a;
    logic [15:0]   fpu_b;
    logic          add_start, add_valid;
    logic [15:0]   add_sum;
    logic          mul_start, mul_valid, mul_uf, mul_of;
    logic [15:0]   mul_product;
    logic          div_start, div_valid, div_uf, div_of;
    logic [15:0]   div_quotient;
    logic          busy;
    logic [1:0]    dbg_state;

    logic [24:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    fpu_op_sequencer #(.TIMEOUT_CYCLES(TMO), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_tag(resp_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b),
        .add_start(add_start), .add_valid(add_valid), .add_sum(add_sum),
        .mul_start(mul_start), .mul_valid(mul_valid), .mul_product(mul_product),
        .mul_uf(mul_uf), .mul_of(mul_of),
        .div_start(div_start), .div_valid(div_valid), .div_quotient(div_quotient),
        .div_uf(div_uf), .div_of(div_of),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- driver tasks ----------------
    task automatic clear_units();
        add_valid = 0; mul_valid = 0; div_valid = 0;
        mul_uf = 0; mul_of = 0; div_uf = 0; div_of = 0;
    endtask

    // unit: 0 = add/sub, 1 = mult, 2 = div. Unselected result buses carry junk.
    task automatic drive_unit(input int unit, input logic [15:0] val, input logic uf, input logic of);
        add_sum = ~val; mul_product = ~val; div_quotient = ~val;
        mul_uf = uf; mul_of = of; div_uf = uf; div_of = of;
        case (unit)
            0: begin add_valid = 1; add_sum = val; end
            1: begin mul_valid = 1; mul_product = val; end
            default: begin div_valid = 1; div_quotient = val; end
        endcase
    endtask

    // One complete op. lat = cycles after the ISSUE cycle at which the unit raises
    // valid (1..TMO); lat = 0 means the unit never answers.
    task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [TW-1:0] tag, input int lat, input logic [15:0] val,
                         input logic uf, input logic of, input int bp, input bit stray);
        logic [4:0]    ef;
        logic [15:0]   er, eb, h_res;
        logic [2:0]    es;
        logic [4:0]    h_flg;
        logic [TW-1:0] h_tag;
        logic [24:0]   exp_v, got_v;
        int cycles, exp_cyc, w, unit;
        bit extra;
        // reference model
        if (lat == 0) begin
            er = 16'h7E00; ef = 5'b10000; exp_cyc = TMO + 1;
        end else begin
            er = val; exp_cyc = lat + 1;
            case (op)
                2'd2: ef = {3'b000, uf, of};
                2'd3: ef = {1'b0, of, uf, 2'b00};
                default: ef = 5'b00000;
            endcase
        end
        eb   = (op == 2'd1) ? (b ^ 16'h8000) : b;
        es   = (op == 2'd2) ? 3'b010 : (op == 2'd3) ? 3'b001 : 3'b100;
        unit = (op < 2'd2) ? 0 : int'(op) - 1;
        exp_q.push_back({tag, ef, er});

        resp_ready = (bp == 0);
        w = 0;
        while (req_ready !== 1'b1 && w < 10) begin @(posedge clk); #1; w++; end
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++; $display("FAIL req_ready_wait: got %b want 1", req_ready); end
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(posedge clk); #1;
        req_valid = 0; req_a = 16'($urandom); req_b = 16'($urandom);
        req_op = 2'($urandom); req_tag = TW'($urandom);
        n_vec++;
        if ({add_start, mul_start, div_start} !== es) begin
            n_err++; $display("FAIL issue_start: got %b want %b", {add_start, mul_start, div_start}, es);
        end
        n_vec++;
        if (fpu_a !== a || fpu_b !== eb) begin
            n_err++; $display("FAIL issue_operands: got %h/%h want %h/%h", fpu_a, fpu_b, a, eb);
        end
        n_vec++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL issue_status: req_ready=%b busy=%b want 0/1", req_ready, busy);
        end
        if (stray) drive_unit(unit, 16'hDEAD, 1'b1, 1'b1);

        cycles = 0; extra = 0;
        while (cycles < TMO + 10) begin
            @(posedge clk); #1; cycles++;
            clear_units();
            if (add_start || mul_start || div_start) extra = 1;
            if (resp_valid === 1'b1) break;
            if (cycles == lat) drive_unit(unit, val, uf, of);
            else if (stray) drive_unit((unit + int'($urandom_range(1, 2))) % 3, 16'($urandom),
                                       1'($urandom), 1'($urandom));
        end
        clear_units();
        n_vec++;
        if (resp_valid !== 1'b1 || cycles != exp_cyc) begin
            n_err++; $display("FAIL resp_latency: got %0d (valid=%b) want %0d", cycles, resp_valid, exp_cyc);
        end
        n_vec++;
        if (extra) begin n_err++; $display("FAIL start_repulse: got 1 want 0"); end

        h_res = resp_result; h_flg = resp_flags; h_tag = resp_tag;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (resp_valid !== 1'b1 || {resp_tag, resp_flags, resp_result} !== {h_tag, h_flg, h_res} ||
                req_ready !== 1'b0 || busy !== 1'b1 || fpu_a !== a || fpu_b !== eb) begin
                n_err++;
                $display("FAIL bp_hold: got v=%b %h/%h/%h rr=%b busy=%b want v=1 %h/%h/%h rr=0 busy=1",
                         resp_valid, resp_tag, resp_flags, resp_result, req_ready, busy, h_tag, h_flg, h_res);
            end
        end
        exp_v = exp_q.pop_front();
        got_v = {resp_tag, resp_flags, resp_result};
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL resp_payload: got tag=%h flags=%b res=%h want tag=%h flags=%b res=%h",
                     got_v[24:21], got_v[20:16], got_v[15:0], exp_v[24:21], exp_v[20:16], exp_v[15:0]);
        end
        resp_ready = 1;
        @(posedge clk); #1;
        n_vec++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_handshake: valid=%b busy=%b req_ready=%b want 0/0/1", resp_valid, busy, req_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 0; req_valid = 0; req_op = 0; req_a = 0; req_b = 0; req_tag = 0;
        resp_ready = 1; add_sum = 0; mul_product = 0; div_quotient = 0;
        clear_units();
        #1;
        n_vec++;
        if ({req_ready, busy, resp_valid, add_start, mul_start, div_start, fpu_a, fpu_b,
             resp_result, resp_flags, resp_tag} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got nonzero want all 0");
        end
        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1; #1;
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge: got %b want 0", req_ready); end
        @(posedge clk); #1;
        n_vec++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL ready_after_release: req_ready=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_add();
        do_op(2'd0, 16'h3C00, 16'h4000, 4'd5, 3, 16'h4200, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_sub();
        do_op(2'd1, 16'h4200, 16'h3C00, 4'd6, 2, 16'h4000, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_mul_overflow();
        do_op(2'd2, 16'h7BFF, 16'h4000, 4'd7, 4, 16'h7C00, 1'b0, 1'b1, 0, 1'b1);
    endtask

    task automatic test_div_timeout();
        bit bad;
        do_op(2'd3, 16'h3C00, 16'h3800, 4'd8, 0, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        drive_unit(2, 16'h1111, 1'b1, 1'b1);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            clear_units();
            if (resp_valid !== 1'b0 || busy !== 1'b0 || div_start !== 1'b0) bad = 1;
        end
        n_vec++;
        if (bad) begin n_err++; $display("FAIL idle_late_valid: got activity want none"); end
    endtask

    task automatic test_timeout_race();
        do_op(2'd3, 16'h1234, 16'h5678, 4'd9, TMO, 16'h0ABC, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(2'd0, 16'h4400, 16'hC000, 4'hA, 1, 16'h4000, 1'b0, 1'b0, 10, 1'b0);
        do_op(2'd2, 16'h3C00, 16'h3C00, 4'hB, 1, 16'h3C00, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        bit bad;
        resp_ready = 1;
        req_valid = 1; req_op = 2'd2; req_a = 16'h5555; req_b = 16'hAAAA; req_tag = 4'hC;
        @(posedge clk); #1;
        req_valid = 0;
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 0;
        #1;
        n_vec++;
        if ({req_ready, busy, resp_valid, add_start, mul_start, div_start, fpu_a, fpu_b,
             resp_result, resp_flags, resp_tag} !== '0) begin
            n_err++; $display("FAIL async_reset: got nonzero outputs want all 0");
        end
        drive_unit(1, 16'h7777, 1'b1, 1'b1);
        @(negedge clk); reset = 1;
        @(posedge clk); #1;
        clear_units();
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: req_ready=%b valid=%b busy=%b want 1/0/0", req_ready, resp_valid, busy);
        end
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0 || add_start || mul_start || div_start) bad = 1;
        end
        n_vec++;
        if (bad) begin n_err++; $display("FAIL post_reset_quiet: got activity want none"); end
        do_op(2'd0, 16'h3800, 16'h3800, 4'hD, 2, 16'h3C00, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c0;
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            do_op(2'($urandom), 16'($urandom), 16'($urandom), TW'(i), 1, 16'($urandom),
                  1'($urandom), 1'($urandom), 0, 1'b0);
        n_vec++;
        if (cyc - c0 != 32) begin n_err++; $display("FAIL back_to_back: got %0d cycles want 32", cyc - c0); end
    endtask

    task automatic test_random();
        int lat;
        for (int i = 0; i < 40; i++) begin
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            do_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), TW'($urandom), lat,
                  16'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul_overflow();
        test_div_timeout();
        test_timeout_race();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL queue_drain: got %0d left want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
